// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter.
// The op encoding matches the datapath shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift step in the datapath's shift_op_t encoding.
// This block is purely combinational.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  shift_op_t        op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        case (op)
            SH_LSL:  result = {data[WIDTH-2:0], 1'b0};
            SH_LSR:  result = {1'b0, data[WIDTH-1:1]};
            SH_ASR:  result = {data[WIDTH-1], data[WIDTH-1:1]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Start/done coprocessor: applies shift_step shift_amt times to the captured operand.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one shift step per clock, count holds steps remaining
//   DONE  | shift_out final, done pulses; start accepted as in IDLE
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] shift_in,
    input  logic [1:0]       shift_op,
    input  logic [AMT_W-1:0] shift_amt,
    output logic [WIDTH-1:0] shift_out,
    output logic             busy,
    output logic             done
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    shift_op_t        op_in;
    shift_op_t        op_q;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] step_res;
    logic [AMT_W-1:0] count;
    logic             accept;

    assign op_in = shift_op_t'(shift_op);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data   (result),
        .op     (op_q),
        .result (step_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    accept = 1'b1;
                    // A zero-length or no-op request completes without entering RUN.
                    if (shift_amt == '0 || op_in == SH_NONE) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (count == AMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            count  <= '0;
            op_q   <= SH_NONE;
        end else if (accept) begin
            result <= shift_in;
            count  <= shift_amt;
            op_q   <= op_in;
        end else if (state == RUN) begin
            result <= step_res;
            count  <= count - AMT_W'(1);
        end
    end

    assign shift_out = result;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: driver pushes expected operations,
// a negedge monitor checks busy/done timing and shift_out against an arithmetic model.
module tb_seq_shifter;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    typedef struct {
        int               start_cyc;
        int               k;
        logic [WIDTH-1:0] din;
        logic [1:0]       op;
    } item_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] shift_in;
    logic [1:0]       shift_op;
    logic [AMT_W-1:0] shift_amt;
    logic [WIDTH-1:0] shift_out;
    logic             busy;
    logic             done;

    item_t            q[$];
    logic [WIDTH-1:0] last_res;
    int               cyc;
    int               n_cmp;
    int               n_bad;

    seq_shifter #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift_in  (shift_in),
        .shift_op  (shift_op),
        .shift_amt (shift_amt),
        .shift_out (shift_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] ref_shift(logic [WIDTH-1:0] d, logic [1:0] op, int n);
        case (op)
            2'b01:   return d << n;
            2'b10:   return d >> n;
            2'b11:   return WIDTH'($signed(d) >>> n);
            default: return d;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit can_accept();
        if (q.size() == 0) return 1'b1;
        return (q.size() == 1 && cyc == q[0].start_cyc + 1 + q[0].k);
    endfunction

    // Driver-side tasks are entered 1 time unit after a rising edge.
    task automatic issue(logic [WIDTH-1:0] d, logic [1:0] op, logic [AMT_W-1:0] amt);
        item_t it;
        int    guard;
        guard = 0;
        while (!can_accept() && guard < 40) begin
            @(posedge clk) #1;
            guard++;
        end
        if (!can_accept()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_wait: got busy expected idle within 40 cycles (cycle %0d)", cyc);
            return;
        end
        start     = 1'b1;
        shift_in  = d;
        shift_op  = op;
        shift_amt = amt;
        it.start_cyc = cyc;
        it.k         = (op == 2'b00) ? 0 : int'(amt);
        it.din       = d;
        it.op        = op;
        q.push_back(it);
        @(posedge clk) #1;
        start     = 1'b0;
        shift_in  = $urandom;
        shift_op  = 2'($urandom);
        shift_amt = AMT_W'($urandom);
    endtask

    task automatic poke(logic [WIDTH-1:0] d, logic [1:0] op, logic [AMT_W-1:0] amt);
        if (!can_accept()) begin
            start     = 1'b1;
            shift_in  = d;
            shift_op  = op;
            shift_amt = amt;
            @(posedge clk) #1;
            start = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk) #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0 (cycle %0d)", q.size(), cyc);
        end
    endtask

    always @(negedge clk) begin
        logic             exp_busy;
        logic             exp_done;
        logic [WIDTH-1:0] exp_out;
        if (!rst) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_out  = last_res;
            if (q.size() > 0) begin
                if (cyc >= q[0].start_cyc + 1 && cyc <= q[0].start_cyc + q[0].k) begin
                    exp_busy = 1'b1;
                    exp_out  = ref_shift(q[0].din, q[0].op, cyc - q[0].start_cyc - 1);
                end
                if (cyc == q[0].start_cyc + 1 + q[0].k) begin
                    exp_done = 1'b1;
                    exp_out  = ref_shift(q[0].din, q[0].op, q[0].k);
                end
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk(exp_done ? "result" : (exp_busy ? "partial" : "hold"), 32'(shift_out), 32'(exp_out));
            if (exp_done) begin
                last_res = exp_out;
                void'(q.pop_front());
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        last_res  = '0;
        rst       = 1'b1;
        start     = 1'b0;
        shift_in  = '0;
        shift_op  = '0;
        shift_amt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'(shift_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        #2 rst = 1'b0;
        @(posedge clk) #1;

        issue(16'hA455, 2'b01, 4'd1);
        issue(16'hA455, 2'b11, 4'd4);
        issue(16'hA455, 2'b10, 4'd4);
        issue(16'h8000, 2'b10, 4'd15);
        issue(16'h8000, 2'b11, 4'd15);
        issue(16'h0001, 2'b01, 4'd15);
        issue(16'hA455, 2'b00, 4'd7);
        issue(16'hA455, 2'b01, 4'd0);
        drain();
        repeat (2) @(posedge clk) #1;

        // Start during RUN must be ignored; the next start lands in the done cycle.
        issue(16'hA455, 2'b11, 4'd4);
        @(posedge clk) #1;
        poke(16'h1234, 2'b01, 4'd9);
        issue(16'h0F0F, 2'b10, 4'd3);
        drain();

        // Asynchronous reset in the middle of an amt=8 run.
        issue(16'h5A5A, 2'b01, 4'd8);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        last_res = '0;
        #1;
        chk("abort_out", 32'(shift_out), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        @(posedge clk) #3;
        rst = 1'b0;
        @(posedge clk) #1;
        issue(16'h00F0, 2'b01, 4'd4);
        drain();

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk) #1;
            issue(WIDTH'($urandom), 2'($urandom), AMT_W'($urandom));
            if ($urandom_range(0, 3) == 0) poke(WIDTH'($urandom), 2'($urandom), AMT_W'($urandom));
        end
        drain();
        repeat (3) @(posedge clk) #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
